// File: rtl/vm2_vic.sv
// vm2_vic: vectored interrupt responder for the VM2 virq/istb/ivec/iack handshake.
// Fixed priority (index 0 highest); all outputs registered.
module vm2_vic #(
  parameter int          N            = 8,
  parameter logic [15:0] SPURIOUS_VEC = 16'o000000
) (
  input  logic            clk_p,
  input  logic            rst,
  input  logic [N-1:0]    ireq,
  input  logic [16*N-1:0] dev_vec,
  output logic [N-1:0]    dev_ack,
  output logic            virq,
  input  logic            istb,
  output logic [15:0]     ivec,
  output logic            iack
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE, PEND, ACK, RELEASE
  } state_t;

  state_t          state, state_n;
  logic [SW-1:0]   sel, sel_n, pri;
  logic            any_req, sel_req;
  logic [15:0]     sel_vec;
  logic            virq_n, iack_n;
  logic [15:0]     ivec_n;
  logic [N-1:0]    dev_ack_n;

  // Lowest set index wins; also pick out the selected source's request/vector
  always_comb begin
    pri     = '0;
    sel_req = 1'b0;
    sel_vec = '0;
    any_req = |ireq;
    for (int i = N - 1; i >= 0; i--) begin
      if (ireq[i]) pri = SW'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (SW'(i) == sel) begin
        sel_req = ireq[i];
        sel_vec = dev_vec[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      virq    <= 1'b0;
      iack    <= 1'b0;
      ivec    <= '0;
      dev_ack <= '0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      virq    <= virq_n;
      iack    <= iack_n;
      ivec    <= ivec_n;
      dev_ack <= dev_ack_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_n = PEND;
          sel_n   = pri;
        end else if (istb) begin
          state_n = ACK;
        end
      end
      PEND: begin
        // strobe beats a same-cycle withdrawal
        if (istb)          state_n = ACK;
        else if (!sel_req) state_n = IDLE;
        else if (pri < sel) sel_n = pri;
      end
      ACK:     state_n = RELEASE;
      RELEASE: if (!istb) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state and registered
  always_comb begin
    virq_n    = (state_n == PEND);
    iack_n    = (state_n == ACK) || (state_n == RELEASE);
    ivec_n    = ivec;
    dev_ack_n = '0;
    if (state == PEND && state_n == ACK) begin
      ivec_n = sel_vec;
      for (int i = 0; i < N; i++) begin
        dev_ack_n[i] = (SW'(i) == sel);
      end
    end else if (state == IDLE && state_n == ACK) begin
      ivec_n = SPURIOUS_VEC;
    end else if (state_n == IDLE) begin
      ivec_n = '0;
    end
  end

endmodule

// File: tb/tb_vm2_vic.sv
// tb_vm2_vic: scoreboard bench for vm2_vic.
// Expected handshakes are queued when stimulus is driven, compared on iack rise.
module tb_vm2_vic;

  localparam logic [15:0] SPUR = 16'o000774;

  logic         clk_p = 1'b0;
  logic         rst;
  logic [7:0]   ireq;
  logic [127:0] dev_vec;
  logic [7:0]   dev_ack;
  logic         virq;
  logic         istb;
  logic [15:0]  ivec;
  logic         iack;

  typedef struct {
    logic [15:0] vec;
    logic [7:0]  ack;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  logic iack_q   = 1'b0;

  logic [15:0] vecs [8] = '{16'o000001, 16'o000014, 16'o000020, 16'o000060,
                            16'o000070, 16'o000105, 16'o000120, 16'o000377};

  vm2_vic #(.N(8), .SPURIOUS_VEC(SPUR)) dut (
    .clk_p   (clk_p),
    .rst     (rst),
    .ireq    (ireq),
    .dev_vec (dev_vec),
    .dev_ack (dev_ack),
    .virq    (virq),
    .istb    (istb),
    .ivec    (ivec),
    .iack    (iack)
  );

  always #5 clk_p = ~clk_p;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_p);
    #1;
  endtask

  task automatic expect_hs(input logic [15:0] v, input logic [7:0] a);
    exp_t e;
    e.vec = v;
    e.ack = a;
    sb.push_back(e);
  endtask

  // CPU strobe; device clears its request on dev_ack; CPU drops strobe
  task automatic handshake();
    int n;
    istb = 1'b1;
    n = 0;
    step();
    while (!iack && n < 10) begin
      step();
      n++;
    end
    if (!iack) check("iack_timeout", 0, 1);
    ireq = ireq & ~dev_ack;
    step();
    check("iack_hold", iack, 1);
    istb = 1'b0;
    step();
    check("iack_drop", iack, 0);
    check("ivec_clear", ivec, 0);
    check("virq_after", virq, 0);
  endtask

  // scoreboard side: compare on iack rise, dev_ack must be a single pulse
  always @(negedge clk_p) begin
    if (rst) begin
      iack_q = 1'b0;
    end else begin
      if (iack && !iack_q) begin
        if (sb.size() == 0) begin
          check("unexpected_iack", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ivec", ivec, e.vec);
          check("dev_ack", dev_ack, e.ack);
        end
      end else if (iack && iack_q) begin
        check("dev_ack_width", dev_ack, 0);
      end
      iack_q = iack;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 8; i++) dev_vec[16*i +: 16] = vecs[i];
    rst  = 1'b1;
    ireq = '0;
    istb = 1'b0;
    step();
    step();
    check("rst_virq", virq, 0);
    check("rst_iack", iack, 0);
    check("rst_ivec", ivec, 0);
    check("rst_dev_ack", dev_ack, 0);
    rst = 1'b0;
    step();

    // single source
    ireq = 8'b0000_1000;
    #1;
    check("s1_virq_early", virq, 0);
    step();
    check("s1_virq", virq, 1);
    expect_hs(16'o000060, 8'b0000_1000);
    handshake();

    // priority: 4 before 7, then 7
    ireq = 8'b1001_0000;
    step();
    check("s2_virq", virq, 1);
    expect_hs(vecs[4], 8'b0001_0000);
    handshake();
    step();
    check("s2_virq2", virq, 1);
    expect_hs(vecs[7], 8'b1000_0000);
    handshake();

    // preemption in PEND
    ireq = 8'b0010_0000;
    step();
    check("s3_virq", virq, 1);
    ireq[1] = 1'b1;
    step();
    expect_hs(vecs[1], 8'b0000_0010);
    handshake();
    check("s3_req5", ireq, 8'b0010_0000);
    step();
    check("s3_virq5", virq, 1);
    expect_hs(vecs[5], 8'b0010_0000);
    handshake();

    // withdrawal then spurious strobe
    ireq = 8'b0000_0100;
    step();
    check("s4_virq", virq, 1);
    ireq = '0;
    step();
    check("s4_virq_wd", virq, 0);
    step();
    check("s4_virq_idle", virq, 0);
    expect_hs(SPUR, 8'h00);
    handshake();

    // strobe / withdraw collision
    ireq = 8'b0000_0001;
    step();
    check("s5_virq", virq, 1);
    ireq = '0;
    expect_hs(vecs[0], 8'b0000_0001);
    handshake();

    // reset mid-ACK, strobe still held afterwards
    ireq = 8'b0100_0000;
    step();
    check("s6_virq", virq, 1);
    expect_hs(vecs[6], 8'b0100_0000);
    istb = 1'b1;
    step();
    check("s6_iack", iack, 1);
    ireq = '0;
    @(negedge clk_p);
    #1;
    rst = 1'b1;
    #1;
    check("s6_rst_iack", iack, 0);
    check("s6_rst_virq", virq, 0);
    check("s6_rst_ivec", ivec, 0);
    check("s6_rst_dev_ack", dev_ack, 0);
    step();
    rst = 1'b0;
    expect_hs(SPUR, 8'h00);
    step();
    check("s6_spur_iack", iack, 1);
    check("s6_spur_ivec", ivec, SPUR);
    istb = 1'b0;
    n = 0;
    while (iack && n < 10) begin
      step();
      n++;
    end
    check("s6_iack_drop", iack, 0);
    check("s6_ivec_clear", ivec, 0);

    step();
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
